// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Used by rf_wb_fifo and rf_writeback_arbiter.
package rf_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic              RST_RFWR_ENABLE = 1'b0;
  localparam logic [ADDR_W-1:0] RST_RD_ADDRESS  = '0;
  localparam logic [DATA_W-1:0] RST_RD_DATA     = '0;
  localparam logic              RST_ALU_STALL   = 1'b0;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback entries with async active-high reset.
// Exposes every slot plus a per-slot valid bit so the pending-write mask can be built.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]           entry_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  wb_entry_t [DEPTH-1:0] slots;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count_q;
  logic [DEPTH-1:0]      valid_q;
  logic                  do_push;
  logic                  do_pop;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign head        = slots[rd_ptr];
  assign entries     = slots;
  assign entry_valid = valid_q;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; slot validity is tracked separately.
  always_ff @(posedge clock) begin
    if (do_push) begin
      slots[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and memory results onto the single register-file write port (ALU priority,
// memory results queued, starvation-forced drain). Define RF_WB_SCOREBOARD_EN for the rf_busy mask.
module rf_writeback_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_stall,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   rfwr_enable,
  output logic [ADDR_W-1:0]      rd_address,
`ifdef RF_WB_SCOREBOARD_EN
  output logic [2**ADDR_W-1:0]   rf_busy,
`endif
  output logic [DATA_W-1:0]      rd_data
);

  import rf_wb_pkg::*;

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = STARVE_LIMIT[CNT_W-1:0];

  wb_entry_t                     push_entry;
  wb_entry_t                     fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  wb_entry_t [FIFO_DEPTH-1:0]    fifo_entries;
  logic [FIFO_DEPTH-1:0]         fifo_valid;

  logic             alu_win;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;

  // x0 results are dropped: the ALU loses its claim and memory is handshaken but not queued.
  assign alu_win    = alu_valid && (alu_rd != '0);
  assign mem_ready  = !fifo_full;
  assign push       = mem_valid && mem_ready && (mem_rd != '0);
  assign pop        = !alu_win && !fifo_empty;
  assign push_entry = '{rd: mem_rd, data: mem_data};

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entries     (fifo_entries),
    .entry_valid (fifo_valid)
  );

  // Saturates at the limit so an ALU that ignores the stall keeps getting stalled.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (alu_win && (starve_cnt != STARVE_MAX)) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      alu_stall   <= RST_ALU_STALL;
      rfwr_enable <= RST_RFWR_ENABLE;
      rd_address  <= RST_RD_ADDRESS;
      rd_data     <= RST_RD_DATA;
    end else begin
      starve_cnt  <= starve_next;
      alu_stall   <= (starve_next == STARVE_MAX);
      rfwr_enable <= alu_win || pop;
      if (alu_win) begin
        rd_address <= alu_rd;
        rd_data    <= alu_data;
      end else if (pop) begin
        rd_address <= fifo_head.rd;
        rd_data    <= fifo_head.data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  always_comb begin
    rf_busy = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        rf_busy[fifo_entries[i].rd] = 1'b1;
      end
    end
    if (rfwr_enable) begin
      rf_busy[rd_address] = 1'b1;
    end
    rf_busy[0] = 1'b0;
  end

  logic unused_fifo_state;
  assign unused_fifo_state = ^fifo_count;
`else
  logic unused_fifo_state;
  assign unused_fifo_state = ^{fifo_count, fifo_entries, fifo_valid};
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: expected writes are queued at stimulus time and
// checked at each negedge; directed checks cover latency, full FIFO, starvation and reset.
module tb_rf_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rfwr_enable;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] rf_busy;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         mem_q[$];
  wr_t         mon_e;
  int          total = 0;
  int          bad = 0;
  int          strobe_cnt = 0;
  logic        alu_pend = 1'b0;
  logic [4:0]  alu_pend_rd = '0;
  logic [31:0] alu_pend_data = '0;

  logic        rdy[40];
  logic        stl[40];
  logic        we[40];
  logic [4:0]  ad[40];
  logic        acc;
  int          acc_cnt;

  always #5 clock = ~clock;

  rf_writeback_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .rfwr_enable (rfwr_enable),
    .rd_address  (rd_address),
`ifdef RF_WB_SCOREBOARD_EN
    .rf_busy     (rf_busy),
`endif
    .rd_data     (rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Outputs seen at a negedge reflect the previous rising edge; inputs seen here are what the next edge samples.
  always @(negedge clock) begin
    if (reset) begin
      alu_pend = 1'b0;
    end else begin
      if (rfwr_enable) strobe_cnt++;
      if (alu_pend) begin
        check("alu_we", 64'(rfwr_enable), 64'd1);
        check("alu_wr", {27'd0, rd_address, rd_data}, {27'd0, alu_pend_rd, alu_pend_data});
      end else if (rfwr_enable) begin
        if (mem_q.size() == 0) begin
          check("spurious_wr", 64'(rfwr_enable), 64'd0);
        end else begin
          mon_e = mem_q.pop_front();
          check("mem_wr", {27'd0, rd_address, rd_data}, {27'd0, mon_e.rd, mon_e.data});
        end
      end
      alu_pend      = alu_valid && (alu_rd != 5'd0);
      alu_pend_rd   = alu_rd;
      alu_pend_data = alu_data;
      if (mem_valid && mem_ready && (mem_rd != 5'd0)) begin
        mem_q.push_back('{rd: mem_rd, data: mem_data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    step(); step();
    check("rst_we", 64'(rfwr_enable), 64'd0);
    check("rst_addr", 64'(rd_address), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_stall", 64'(alu_stall), 64'd0);
    check("rst_ready", 64'(mem_ready), 64'd1);
`ifdef RF_WB_SCOREBOARD_EN
    check("rst_busy", 64'(rf_busy), 64'd0);
`endif
    reset = 1'b0;
    step();

    // ALU latency 1
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    check("alu_lat_we", 64'(rfwr_enable), 64'd1);
    check("alu_lat_addr", 64'(rd_address), 64'd5);
    check("alu_lat_data", 64'(rd_data), 64'hDEADBEEF);
    step();
    check("alu_lat_off", 64'(rfwr_enable), 64'd0);

    // Memory latency 2
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
    check("mem_rdy_idle", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 1'b0;
    check("mem_lat_c1", 64'(rfwr_enable), 64'd0);
    step();
    check("mem_lat_we", 64'(rfwr_enable), 64'd1);
    check("mem_lat_addr", 64'(rd_address), 64'd7);
    check("mem_lat_data", 64'(rd_data), 64'h11);
    step();
    check("mem_lat_off", 64'(rfwr_enable), 64'd0);

    // x0 from both sources
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hAAAA;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBBBB;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("x0_we", 64'(rfwr_enable), 64'd0);
      step();
    end

    // Five memory results against a busy ALU that honours the stall
    acc_cnt = 0;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h100;
    for (int k = 0; k < 40; k++) begin
      rdy[k] = mem_ready;
      stl[k] = alu_stall;
      alu_valid = !alu_stall;
      alu_rd = 5'(k % 31 + 1);
      alu_data = $urandom;
      acc = mem_valid && mem_ready;
      step();
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 5) mem_valid = 1'b0;
        else begin
          mem_rd = 5'(10 + acc_cnt);
          mem_data = 32'h100 + 32'(acc_cnt);
        end
      end
    end
    alu_valid = 1'b0;
    step(); step(); step();
    check("full_rdy3", 64'(rdy[3]), 64'd1);
    check("full_rdy4", 64'(rdy[4]), 64'd0);
    check("full_stl3", 64'(stl[3]), 64'd0);
    check("full_stl4", 64'(stl[4]), 64'd1);
    check("full_rdy5", 64'(rdy[5]), 64'd1);
    check("full_stl5", 64'(stl[5]), 64'd0);
    check("full_stl8", 64'(stl[8]), 64'd1);
    check("full_acc", 64'(acc_cnt), 64'd5);
    check("full_drain", 64'(mem_q.size()), 64'd0);

    // Starvation: one queued entry, continuous ALU; second pass ignores the stall once
    for (int pass = 0; pass < 2; pass++) begin
      mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0DE + 32'(pass);
      for (int k = 0; k < 10; k++) begin
        stl[k] = alu_stall;
        we[k]  = rfwr_enable;
        ad[k]  = rd_address;
        alu_valid = (pass == 1 && k == 4) ? 1'b1 : !alu_stall;
        alu_rd = 5'(k + 1);
        alu_data = $urandom;
        step();
        mem_valid = 1'b0;
      end
      alu_valid = 1'b0;
      step(); step();
      check("stv_stl3", 64'(stl[3]), 64'd0);
      check("stv_stl4", 64'(stl[4]), 64'd1);
      if (pass == 0) begin
        check("stv_stl5", 64'(stl[5]), 64'd0);
        check("stv_mem_we", 64'(we[5]), 64'd1);
        check("stv_mem_addr", 64'(ad[5]), 64'd12);
        check("stv_alu_resume", 64'(we[6]), 64'd1);
      end else begin
        check("viol_stl5", 64'(stl[5]), 64'd1);
        check("viol_stl6", 64'(stl[6]), 64'd0);
        check("viol_mem_addr", 64'(ad[6]), 64'd12);
      end
    end

    // Pending-write mask for x9
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
`ifdef RF_WB_SCOREBOARD_EN
    check("busy_pre", 64'(rf_busy), 64'd0);
`endif
    step();
    mem_valid = 1'b0;
`ifdef RF_WB_SCOREBOARD_EN
    check("busy_q", 64'(rf_busy), 64'h200);
`endif
    step();
    check("busy_we", 64'(rfwr_enable), 64'd1);
`ifdef RF_WB_SCOREBOARD_EN
    check("busy_strobe", 64'(rf_busy), 64'h200);
`endif
    step();
`ifdef RF_WB_SCOREBOARD_EN
    check("busy_clr", 64'(rf_busy), 64'd0);
`endif
    check("busy_we_off", 64'(rfwr_enable), 64'd0);

    // Reset with three queued entries and a live strobe
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'(k);
      mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_data = 32'h200 + 32'(k);
      step();
    end
    check("pre_rst_we", 64'(rfwr_enable), 64'd1);
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    mem_q.delete();
    #1;
    check("mid_rst_we", 64'(rfwr_enable), 64'd0);
    check("mid_rst_addr", 64'(rd_address), 64'd0);
    check("mid_rst_data", 64'(rd_data), 64'd0);
    check("mid_rst_stall", 64'(alu_stall), 64'd0);
    check("mid_rst_ready", 64'(mem_ready), 64'd1);
`ifdef RF_WB_SCOREBOARD_EN
    check("mid_rst_busy", 64'(rf_busy), 64'd0);
`endif
    step(); step();
    reset = 1'b0;
    strobe_cnt = 0;
    for (int k = 0; k < 8; k++) step();
    check("post_rst_strobes", 64'(strobe_cnt), 64'd0);
    check("post_rst_q", 64'(mem_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
